// File: rtl/tap_delay_line.sv
// ---------------------------------------------------------------------------
// tap_delay_line
//
// Shift-register delay line of DEPTH stages. Each stage carries WIDTH data
// bits plus a valid bit. Any tap (0 = live input, k = stage k) can be read
// out through a select mux.
//
// Optional feature (compile-time macro):
//   TAP_DELAY_LINE_OUT_REG_EN  - register q/q_valid after the tap mux.
//                                This adds one cycle of latency.
//                                Without the macro the mux is purely
//                                combinational.
//
// Parameters:
//   WIDTH  data width (1..64)
//   DEPTH  number of stages (1..16)
//
// Ports:
//   clk         sole clock, rising edge
//   resetn      asynchronous active-low reset
//   en          shift enable
//   flush       synchronous clear of all stages and valid bits (beats en)
//   d, d_valid  input sample and its qualifier (tap 0)
//   sel         tap select, 0..DEPTH; larger values read as 0 and set sel_err
//   q, q_valid  selected tap data and valid bit
//   fill_count  number of stages currently holding valid data
//   sel_err     sticky out-of-range select flag; cleared only by reset
// ---------------------------------------------------------------------------
module tap_delay_line #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 3,
    localparam int SELW  = $clog2(DEPTH + 1),
    localparam int FCW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [SELW-1:0]  sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [FCW-1:0]   fill_count,
    output logic             sel_err
);

    // Index 0 holds stage 1, index DEPTH-1 holds stage DEPTH.
    logic [DEPTH-1:0][WIDTH-1:0] stage_data_q,  stage_data_d;
    logic [DEPTH-1:0]            stage_valid_q, stage_valid_d;
    logic [FCW-1:0]              fill_count_q,  fill_count_d;
    logic                        sel_err_q,     sel_err_d;

    logic                        sel_oor;
    logic [WIDTH-1:0]            tap_data;
    logic                        tap_valid;

    // Widen by one bit so the compare is well defined even when every sel
    // code is a legal tap. In that case the compare is simply always false.
    assign sel_oor = ({1'b0, sel} > (SELW + 1)'(DEPTH));

    // Next-state logic for the stages, the fill counter and the error flag.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first,
        // so no path can leave a value unassigned and infer a latch.
        stage_data_d  = stage_data_q;
        stage_valid_d = stage_valid_q;
        fill_count_d  = '0;
        sel_err_d     = sel_err_q | sel_oor;

        if (flush) begin
            stage_data_d  = '0;
            stage_valid_d = '0;
        end else if (en) begin
            stage_data_d[0]  = d;
            stage_valid_d[0] = d_valid;
            for (int k = 1; k < DEPTH; k++) begin
                stage_data_d[k]  = stage_data_q[k-1];
                stage_valid_d[k] = stage_valid_q[k-1];
            end
        end

        // Popcount of the next valid bits. Registering this keeps
        // fill_count consistent with the stages after every edge.
        for (int k = 0; k < DEPTH; k++) begin
            fill_count_d = fill_count_d + FCW'(stage_valid_d[k]);
        end
    end

    // Tap mux. Out-of-range selects fall through to the zero defaults.
    always_comb begin
        tap_data  = '0;
        tap_valid = 1'b0;
        if (sel == '0) begin
            tap_data  = d;
            tap_valid = d_valid;
        end
        for (int k = 1; k <= DEPTH; k++) begin
            if (sel == SELW'(k)) begin
                tap_data  = stage_data_q[k-1];
                tap_valid = stage_valid_q[k-1];
            end
        end
    end

    // The stages are reset as well, because reset must discard any samples
    // still in flight. It is not enough to clear only the valid bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stage_data_q  <= '0;
            stage_valid_q <= '0;
            fill_count_q  <= '0;
            sel_err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every stage samples its
            // neighbour's pre-edge value and the shift does not ripple.
            stage_data_q  <= stage_data_d;
            stage_valid_q <= stage_valid_d;
            fill_count_q  <= fill_count_d;
            sel_err_q     <= sel_err_d;
        end
    end

    assign fill_count = fill_count_q;
    assign sel_err    = sel_err_q;

`ifdef TAP_DELAY_LINE_OUT_REG_EN
    // The output register samples the mux every cycle, independent of en.
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;

    always_comb begin
        out_data_d  = tap_data;
        out_valid_d = tap_valid;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign q       = out_data_q;
    assign q_valid = out_valid_q;
`else
    assign q       = tap_data;
    assign q_valid = tap_valid;
`endif

endmodule

// File: tb/tb_tap_delay_line.sv
// ---------------------------------------------------------------------------
// tb_tap_delay_line
//
// Two instances share all stimulus except the select width:
//   u_dut3  DEPTH=3  (sel is 2 bits, so no select can be out of range)
//   u_dut4  DEPTH=4  (sel is 3 bits, so selects 5..7 are out of range)
// A behavioural model of both lines predicts every tap. Expected outputs are
// queued when stimulus is driven and popped when the outputs are sampled on
// the falling edge. The queue is pre-seeded with one zero entry in the
// registered-output build, which accounts for the extra cycle of latency.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tap_delay_line;

`ifdef TAP_DELAY_LINE_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic       clk     = 1'b0;
    logic       resetn  = 1'b0;
    logic       en      = 1'b0;
    logic       flush   = 1'b0;
    logic       d_valid = 1'b0;
    logic [7:0] d       = '0;
    logic [2:0] sel     = '0;

    logic [7:0] q3, q4;
    logic       qv3, qv4;
    logic [1:0] fc3;
    logic [2:0] fc4;
    logic       err3, err4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tap_delay_line #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .en(en), .flush(flush),
        .d(d), .d_valid(d_valid), .sel(sel[1:0]),
        .q(q3), .q_valid(qv3), .fill_count(fc3), .sel_err(err3)
    );

    tap_delay_line #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .en(en), .flush(flush),
        .d(d), .d_valid(d_valid), .sel(sel),
        .q(q4), .q_valid(qv4), .fill_count(fc4), .sel_err(err4)
    );

    // ---------------- model + scoreboard ----------------
    typedef struct {
        logic [7:0] q3;
        logic       v3;
        logic [7:0] q4;
        logic       v4;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] md[2][1:4];
    logic       mv[2][1:4];
    logic       m_err4;

    function automatic int dep(input int i);
        return (i == 0) ? 3 : 4;
    endfunction

    function automatic logic [8:0] model_tap(input int i, input int s);
        if (s == 0)
            return {d_valid, d};
        else if (s <= dep(i))
            return {mv[i][s], md[i][s]};
        return 9'd0;
    endfunction

    function automatic int model_fill(input int i);
        int n = 0;
        for (int k = 1; k <= dep(i); k++) n += int'(mv[i][k]);
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++)
            for (int k = 1; k <= 4; k++) begin
                md[i][k] = '0;
                mv[i][k] = 1'b0;
            end
        m_err4 = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // One clock cycle. It is entered 1ns after a rising edge, and it returns
    // 1ns after the next rising edge.
    task automatic step(input logic e, input logic f, input logic dv,
                        input logic [7:0] dd, input logic [2:0] s);
        logic [8:0] t3, t4;
        exp_t       x;
        en = e; flush = f; d_valid = dv; d = dd; sel = s;
        t3 = model_tap(0, int'(s[1:0]));
        t4 = model_tap(1, int'(s));
        exp_q.push_back('{t3[7:0], t3[8], t4[7:0], t4[8]});
        @(negedge clk);
        x = exp_q.pop_front();
        check("q3",   q3,   x.q3);
        check("qv3",  qv3,  x.v3);
        check("q4",   q4,   x.q4);
        check("qv4",  qv4,  x.v4);
        check("fc3",  fc3,  model_fill(0));
        check("fc4",  fc4,  model_fill(1));
        check("err3", err3, 1'b0);
        check("err4", err4, m_err4);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (f) begin
                for (int k = 1; k <= dep(i); k++) begin
                    md[i][k] = '0;
                    mv[i][k] = 1'b0;
                end
            end else if (e) begin
                for (int k = dep(i); k >= 2; k--) begin
                    md[i][k] = md[i][k-1];
                    mv[i][k] = mv[i][k-1];
                end
                md[i][1] = dd;
                mv[i][1] = dv;
            end
        end
        if (int'(s) > 4) m_err4 = 1'b1;
        #1;
    endtask

    // Asynchronous reset pulse between clock edges. Every check here
    // happens before the next rising edge.
    task automatic pulse_reset();
        sel = 3'd3;
        resetn = 1'b0;
        #1;
        check("rst_q3",   q3,   8'h00);
        check("rst_qv3",  qv3,  1'b0);
        check("rst_q4",   q4,   8'h00);
        check("rst_qv4",  qv4,  1'b0);
        check("rst_fc3",  fc3,  2'd0);
        check("rst_fc4",  fc4,  3'd0);
        check("rst_err3", err3, 1'b0);
        check("rst_err4", err4, 1'b0);
        // Tap 0 during reset: follows d only in the combinational build.
        sel = 3'd0; d_valid = 1'b1; d = 8'h5a;
        #1;
        check("rst_tap0_v", qv3, (LAT == 0) ? 1'b1 : 1'b0);
        check("rst_tap0_d", q3,  (LAT == 0) ? 8'h5a : 8'h00);
        d_valid = 1'b0; d = '0;
        #1;
        resetn = 1'b1;
        model_clear();
        exp_q.delete();
        if (LAT == 1) exp_q.push_back('{8'h00, 1'b0, 8'h00, 1'b0});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        @(posedge clk);
        #1;
        pulse_reset();

        // Fill latency: 0x11 reaches tap 3 after three enabled edges.
        step(1, 0, 1, 8'h11, 3'd3);
        step(1, 0, 1, 8'h22, 3'd3);
        step(1, 0, 1, 8'h33, 3'd3);
        check("fill_full", fc3, 2'd3);
        check("tap3_first", q3, (LAT == 0) ? 8'h11 : 8'h00);
        step(1, 0, 1, 8'h44, 3'd3);
        step(0, 0, 0, 8'h00, 3'd3);

        // Hold across disabled cycles: nothing is lost or duplicated.
        step(0, 1, 0, 8'h00, 3'd2);
        step(1, 0, 1, 8'h11, 3'd2);
        step(1, 0, 1, 8'h22, 3'd2);
        repeat (5) step(0, 0, 1, 8'hee, 3'd2);
        step(1, 0, 1, 8'h33, 3'd2);
        step(0, 0, 0, 8'h00, 3'd2);
        step(1, 0, 1, 8'h44, 3'd2);
        step(0, 0, 0, 8'h00, 3'd2);

        // Flush wins over a simultaneous shift.
        step(1, 0, 1, 8'h01, 3'd1);
        step(1, 0, 1, 8'h02, 3'd1);
        step(1, 0, 1, 8'h03, 3'd1);
        step(1, 0, 1, 8'h04, 3'd1);
        step(1, 1, 1, 8'haa, 3'd3);
        check("fill_flush", fc3, 2'd0);
        step(0, 0, 0, 8'h00, 3'd1);
        step(0, 0, 0, 8'h00, 3'd2);
        step(0, 0, 0, 8'h00, 3'd3);

        // Alternating valid bits.
        step(1, 0, 1, 8'ha1, 3'd0);
        step(1, 0, 0, 8'hb2, 3'd0);
        step(1, 0, 1, 8'hc3, 3'd0);
        check("fill_alt", fc3, 2'd2);
        step(0, 0, 0, 8'h00, 3'd3);
        step(0, 0, 0, 8'h00, 3'd2);
        step(0, 0, 0, 8'h00, 3'd1);
        step(0, 0, 1, 8'h99, 3'd4);

        // Random traffic. Selects stay in range for both instances here.
        for (int n = 0; n < 60; n++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                 1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 4)));

        // Out-of-range select on the DEPTH=4 instance. The flag is sticky
        // across a flush.
        step(1, 0, 1, 8'h5c, 3'd6);
        check("sel_err_set", err4, 1'b1);
        step(0, 0, 0, 8'h00, 3'd7);
        step(0, 0, 1, 8'h3c, 3'd5);
        step(0, 1, 0, 8'h00, 3'd1);
        check("sel_err_sticky", err4, 1'b1);
        step(0, 0, 0, 8'h00, 3'd0);

        // Reset mid-stream with a full pipeline. The first enabled edge
        // after reset loads stage 1 only.
        step(1, 0, 1, 8'h71, 3'd3);
        step(1, 0, 1, 8'h72, 3'd3);
        step(1, 0, 1, 8'h73, 3'd3);
        step(1, 0, 1, 8'h74, 3'd3);
        pulse_reset();
        step(1, 0, 1, 8'h77, 3'd1);
        step(0, 0, 0, 8'h00, 3'd1);
        step(0, 0, 0, 8'h00, 3'd2);
        step(0, 0, 0, 8'h00, 3'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tap_delay_line.md
TAP_DELAY_LINE -- requirements
Module: tap_delay_line

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 3: number of pipeline stages, legal range 1..16.
REQ-003 Derived SELW = $clog2(DEPTH+1): tap-select width; FCW = $clog2(DEPTH+1): fill-count width.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 resetn  in  1  reset, asynchronous and active-low.
REQ-006 en  in  1  shift enable; stages advance only when high.
REQ-007 flush  in  1  synchronous clear of all stages and valid bits.
REQ-008 d  in  WIDTH  input sample.
REQ-009 d_valid  in  1  qualifies d.
REQ-010 sel  in  SELW  tap select: 0 = input, k = output of stage k.
REQ-011 q  out  WIDTH  selected tap data.
REQ-012 q_valid  out  1  valid bit of the selected tap.
REQ-013 fill_count  out  FCW  number of stages currently holding valid data, 0..DEPTH.
REQ-014 sel_err  out  1  sticky flag, set when sel > DEPTH.

Function
REQ-015 Each stage k (1..DEPTH) SHALL hold WIDTH data bits plus one valid bit.
REQ-016 On a rising edge with en=1 and flush=0: stage 1 SHALL load {d_valid, d}, and stage k SHALL load stage k-1 for k = 2..DEPTH.
REQ-017 With en=0 and flush=0, all stages SHALL hold their value.
REQ-018 flush=1 SHALL clear all stage data to 0 and all valid bits to 0 on the next edge, regardless of en. Flush wins over a simultaneous shift.
REQ-019 Tap 0 SHALL be {d_valid, d}. Tap k SHALL be stage k.
REQ-020 For sel in 0..DEPTH, q and q_valid SHALL present the selected tap, subject to the latency in REQ-028/029.
REQ-021 For sel > DEPTH, q SHALL be 0 and q_valid SHALL be 0.
REQ-022 For sel > DEPTH, sel_err SHALL set on the next edge and remain set until reset. Flush SHALL NOT clear sel_err.
REQ-023 fill_count SHALL be a register equal to the popcount of the stage valid bits after each edge.
REQ-024 fill_count SHALL saturate naturally at DEPTH and return to 0 on flush.
REQ-025 Data SHALL enter at stage 1 and be visible on tap k exactly k enabled edges later.
REQ-026 Data SHALL NOT be lost or duplicated across disabled cycles.
REQ-027 A change of sel SHALL NOT disturb stage contents.

Configuration
REQ-028 With macro TAP_DELAY_LINE_OUT_REG_EN defined, q and q_valid SHALL be registered from the tap mux every cycle, independent of en. This adds exactly one cycle of latency from tap to output. q and q_valid SHALL reset to 0.
REQ-029 Without TAP_DELAY_LINE_OUT_REG_EN, q and q_valid SHALL be a purely combinational mux of the taps with zero added latency. sel=0 then passes d through combinationally.

Reset
REQ-030 resetn=0 SHALL immediately, without waiting for clk, clear:
- all stage data and valid bits to 0;
- fill_count to 0;
- sel_err to 0;
- the output registers, if present, to 0.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight samples. After resetn deasserts, the first enabled edge SHALL load stage 1 only.
REQ-032 With sel in 0..DEPTH during reset, q_valid SHALL read 0, except tap 0 in the combinational build, which follows d_valid.

Verification
REQ-033 DEPTH=3, en=1, d_valid=1, d=0x11,0x22,0x33,0x44 on edges 1..4, sel=3 -> q=0x11 with q_valid=1 after edge 3 (after edge 4 with OUT_REG); fill_count=3 from edge 3.
REQ-034 Load 0x11,0x22 with en=1, then hold en=0 for 5 cycles, then en=1 with d=0x33 -> stage 2 reads 0x11, then 0x22 after the third enabled edge; no loss or duplication.
REQ-035 Full pipeline (fill_count=3), assert flush and en together with d=0xAA -> after the edge all taps 1..3 read 0 with q_valid=0 and fill_count=0.
REQ-036 Alternate d_valid 1,0,1 with en=1 -> fill_count=2; tap valid bits read 1,0,1 on stages 3,2,1.
REQ-037 DEPTH=3, sel=3'd... any SELW value above 3 is unreachable when SELW=2; use DEPTH=4 with sel=6 -> q=0, q_valid=0, sel_err=1 after the edge; sel_err stays 1 through a flush and clears only on resetn=0.
REQ-038 Pulse resetn low between clock edges while the pipeline is full -> all outputs read 0 before the next edge; fill_count=0.
